fp2_mul_arbiter: RTL and testbench
==================================

// Module: fp2_mul_arbiter
// PURPOSE
//   Shares one fp2_mont_mul core between NUM_REQ requesters (e.g. isogeny step engines).
//   Grants the core round-robin, pulses its start, and watches done/busy with a watchdog.
//   Reports per-requester completion or timeout.
//   Exports a grant index so the enclosing wrapper can mux the a_0/a_1/b_0/b_1 and
//   sub/add result memory ports to the granted requester.
// PARAMETERS
//   NUM_REQ        4     number of requesters (>=2)
//   NUM_REQ_LOG    2     `CLOG2(NUM_REQ), width of sel
//   TIMEOUT_CYCLES 4096  max cycles in WAIT without mul_done before error
//   TIMEOUT_LOG    13    `CLOG2(TIMEOUT_CYCLES+1), watchdog counter width
// PORTS
//   clk        in   1             single clock, all logic on posedge
//   rst        in   1             asynchronous, active-low reset
//   req        in   NUM_REQ       level request; held high until matching req_done
//   gnt        out  NUM_REQ       one-hot grant, registered
//   sel        out  NUM_REQ_LOG   index of granted requester (memory mux select)
//   req_done   out  NUM_REQ       1-cycle pulse: operation for that requester finished
//   req_err    out  NUM_REQ       1-cycle pulse with req_done: watchdog expired
//   mul_start  out  1             1-cycle start pulse to fp2_mont_mul
//   mul_done   in   1             done from fp2_mont_mul (pulse or level)
//   mul_busy   in   1             busy from fp2_mont_mul
//   arb_busy   out  1             high in every state except IDLE
//   mul_count  out  32            count of successful (non-timeout) operations, wraps
// BEHAVIOUR
//   Reset (rst=0, immediate): state=IDLE; gnt, sel, req_done, req_err, mul_start,
//     mul_count, watchdog = 0; rr pointer = NUM_REQ-1 so requester 0 has first priority.
//   FSM: IDLE -> GRANT -> START -> WAIT -> RELEASE -> IDLE.
//   IDLE:
//     - If any req bit is set and mul_busy=0: pick the first set bit searching
//       ptr+1, ptr+2, ... (mod NUM_REQ).
//     - Register gnt/sel, set ptr to the winner, go to GRANT.
//     - If mul_busy=1, no grant is issued; stay in IDLE.
//   GRANT: one cycle for the memory mux to settle; gnt held. Go to START.
//   START: mul_start=1 for exactly this cycle; clear watchdog; go to WAIT.
//   WAIT:
//     - Watchdog increments each cycle.
//     - mul_done=1: go to RELEASE (ok).
//     - Else watchdog reaches TIMEOUT_CYCLES: go to RELEASE (error).
//     - If both occur in the same cycle, done wins.
//   RELEASE:
//     - req_done[sel]=1; req_err[sel]=1 only on timeout.
//     - mul_count += 1 only on ok.
//     - gnt still held this cycle; it clears on entry to IDLE.
//   mul_done is ignored outside WAIT; a stale done cannot complete a later operation.
//   req is sampled only in IDLE; dropping req mid-operation does not abort the core.
//     The op runs to completion and req_done still pulses.
//   A requester that keeps req high after req_done is re-eligible, but round-robin places
//     it last behind any other pending requester.
//   Timing: req seen in IDLE at cycle t -> gnt at t+1, mul_start at t+2.
//     mul_done seen at cycle d -> req_done at d+1, gnt low at d+2.
//     Earliest next gnt is at d+3.
//   gnt is always one-hot or zero; sel is valid whenever gnt!=0, 0 otherwise.
//   Reset mid-operation returns to IDLE at once. The core is not reset by this block;
//     the mul_busy check in IDLE blocks the next grant until the core drains.
// TESTING
//   1. Single req[2] held, core model done after 50 cycles ->
//      gnt=4'b0100 and sel=2 at t+1; one mul_start at t+2;
//      req_done[2] one cycle; mul_count=1.
//   2. req=4'b1111 continuously for 8 ops -> grant order 0,1,2,3,0,1,2,3;
//      exactly 8 mul_start pulses; mul_count=8.
//   3. Core never asserts mul_done, TIMEOUT_CYCLES=16 ->
//      req_done[k] and req_err[k] pulse 17 cycles after mul_start; mul_count unchanged.
//   4. mul_done pulse injected during GRANT, then real done later ->
//      exactly one req_done, on the real done.
//   5. rst=0 while in WAIT, then mul_busy held high 20 cycles after release with req=4'b0001 ->
//      all outputs 0 immediately; no gnt until mul_busy falls; then requester 0 granted.
//   6. mul_done and watchdog expiry in the same cycle -> req_done with req_err=0;
//      mul_count increments.

Source files
------------

// File: rtl/fp2_mul_arbiter.sv
// Round-robin arbiter sharing one fp2_mont_mul core between NUM_REQ requesters.
// Pulses the core start, watches done with a watchdog, reports completion/timeout.
module fp2_mul_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int NUM_REQ_LOG    = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TIMEOUT_LOG    = 13
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    output logic [NUM_REQ-1:0]     gnt,
    output logic [NUM_REQ_LOG-1:0] sel,
    output logic [NUM_REQ-1:0]     req_done,
    output logic [NUM_REQ-1:0]     req_err,
    output logic                   mul_start,
    input  logic                   mul_done,
    input  logic                   mul_busy,
    output logic                   arb_busy,
    output logic [31:0]            mul_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_START,
        S_WAIT,
        S_REL
    } state_t;

    state_t                 state, state_nx;
    logic [NUM_REQ-1:0]     gnt_nx;
    logic [NUM_REQ_LOG-1:0] sel_nx;
    logic [NUM_REQ_LOG-1:0] ptr, ptr_nx;
    logic [NUM_REQ_LOG-1:0] win;
    logic                   found;
    logic [TIMEOUT_LOG-1:0] wd, wd_nx;
    logic                   err, err_nx;
    logic [31:0]            count_nx;

    // First pending requester after the last winner, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!found && req[NUM_REQ_LOG'((int'(ptr) + i) % NUM_REQ)]) begin
                found = 1'b1;
                win   = NUM_REQ_LOG'((int'(ptr) + i) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_nx  = state;
        gnt_nx    = gnt;
        sel_nx    = sel;
        ptr_nx    = ptr;
        wd_nx     = wd;
        err_nx    = err;
        count_nx  = mul_count;
        mul_start = 1'b0;
        req_done  = '0;
        req_err   = '0;
        case (state)
            S_IDLE: begin
                if (found && !mul_busy) begin
                    gnt_nx   = NUM_REQ'(1) << win;
                    sel_nx   = win;
                    ptr_nx   = win;
                    state_nx = S_GRANT;
                end
            end
            S_GRANT: state_nx = S_START;
            S_START: begin
                mul_start = 1'b1;
                wd_nx     = '0;
                err_nx    = 1'b0;
                state_nx  = S_WAIT;
            end
            S_WAIT: begin
                wd_nx = wd + 1'b1;
                // A done in the expiry cycle still counts as success.
                if (mul_done) begin
                    err_nx   = 1'b0;
                    state_nx = S_REL;
                end else if (wd_nx == TIMEOUT_LOG'(TIMEOUT_CYCLES)) begin
                    err_nx   = 1'b1;
                    state_nx = S_REL;
                end
            end
            S_REL: begin
                req_done = gnt;
                req_err  = err ? gnt : '0;
                if (!err) count_nx = mul_count + 32'd1;
                gnt_nx   = '0;
                sel_nx   = '0;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            gnt       <= '0;
            sel       <= '0;
            ptr       <= NUM_REQ_LOG'(NUM_REQ - 1);
            wd        <= '0;
            err       <= 1'b0;
            mul_count <= '0;
        end else begin
            state     <= state_nx;
            gnt       <= gnt_nx;
            sel       <= sel_nx;
            ptr       <= ptr_nx;
            wd        <= wd_nx;
            err       <= err_nx;
            mul_count <= count_nx;
        end
    end

    assign arb_busy = (state != S_IDLE);

endmodule

// File: tb/tb_fp2_mul_arbiter.sv
// Directed bench for fp2_mul_arbiter: one instance at the default watchdog,
// one with a 16-cycle watchdog for the timeout cases.
module tb_fp2_mul_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] req, req_b;
    logic       mul_done, mul_busy, done_b, busy_b;

    logic [3:0]  gnt, req_done, req_err;
    logic [1:0]  sel;
    logic        mul_start, arb_busy;
    logic [31:0] mul_count;

    logic [3:0]  gnt_b, rd_b, re_b;
    logic [1:0]  sel_b;
    logic        start_b, abusy_b;
    logic [31:0] cnt_b;

    fp2_mul_arbiter u_dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .sel(sel),
        .req_done(req_done), .req_err(req_err),
        .mul_start(mul_start), .mul_done(mul_done),
        .mul_busy(mul_busy), .arb_busy(arb_busy),
        .mul_count(mul_count)
    );

    fp2_mul_arbiter #(
        .NUM_REQ(4), .NUM_REQ_LOG(2),
        .TIMEOUT_CYCLES(16), .TIMEOUT_LOG(5)
    ) u_wd (
        .clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b), .sel(sel_b),
        .req_done(rd_b), .req_err(re_b),
        .mul_start(start_b), .mul_done(done_b),
        .mul_busy(busy_b), .arb_busy(abusy_b),
        .mul_count(cnt_b)
    );

    int checks = 0;
    int failures = 0;
    int n_start = 0;
    int n_done = 0;
    int base_s, base_d;
    logic saw;

    always @(negedge clk) begin
        if (mul_start) n_start++;
        if (req_done != 4'b0) n_done++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; req = '0; mul_done = 1'b0; mul_busy = 1'b0;
        req_b = '0; done_b = 1'b0; busy_b = 1'b0;
        repeat (3) tick();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_start", 32'(mul_start), 0);
        chk("rst_done", 32'(req_done), 0);
        chk("rst_err", 32'(req_err), 0);
        chk("rst_busy", 32'(arb_busy), 0);
        chk("rst_count", mul_count, 0);
        rst = 1'b1;
        tick();

        // single request, core done 50 cycles into WAIT
        base_s = n_start; base_d = n_done;
        req = 4'b0100;
        tick();
        chk("t1_gnt", 32'(gnt), 32'h4);
        chk("t1_sel", 32'(sel), 2);
        chk("t1_start_early", 32'(mul_start), 0);
        tick();
        chk("t1_start", 32'(mul_start), 1);
        chk("t1_arb_busy", 32'(arb_busy), 1);
        repeat (50) tick();
        chk("t1_wait_gnt", 32'(gnt), 32'h4);
        chk("t1_wait_done", 32'(req_done), 0);
        mul_done = 1'b1;
        tick();
        chk("t1_req_done", 32'(req_done), 32'h4);
        chk("t1_req_err", 32'(req_err), 0);
        chk("t1_rel_gnt", 32'(gnt), 32'h4);
        mul_done = 1'b0; req = '0;
        tick();
        chk("t1_gnt_clr", 32'(gnt), 0);
        chk("t1_count", mul_count, 1);
        chk("t1_n_start", 32'(n_start - base_s), 1);
        chk("t1_n_done", 32'(n_done - base_d), 1);

        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();

        // all four requesting: round-robin from requester 0
        base_s = n_start;
        req = 4'b1111;
        for (int op = 0; op < 8; op++) begin
            tick();
            chk("t2_gnt", 32'(gnt), 32'(1) << (op % 4));
            chk("t2_sel", 32'(sel), 32'(op % 4));
            tick();
            chk("t2_start", 32'(mul_start), 1);
            tick();
            mul_done = 1'b1;
            tick();
            chk("t2_done", 32'(req_done), 32'(1) << (op % 4));
            mul_done = 1'b0;
            if (op == 7) req = '0;
            tick();
        end
        chk("t2_count", mul_count, 8);
        chk("t2_n_start", 32'(n_start - base_s), 8);

        // watchdog expiry: done/err 17 cycles after start
        req_b = 4'b0010;
        tick();
        chk("t3_gnt", 32'(gnt_b), 32'h2);
        tick();
        chk("t3_start", 32'(start_b), 1);
        saw = 1'b0;
        repeat (16) begin
            tick();
            if (rd_b != 4'b0) saw = 1'b1;
        end
        chk("t3_early_done", 32'(saw), 0);
        tick();
        chk("t3_done", 32'(rd_b), 32'h2);
        chk("t3_err", 32'(re_b), 32'h2);
        req_b = '0;
        tick();
        chk("t3_count", cnt_b, 0);
        chk("t3_gnt_clr", 32'(gnt_b), 0);

        // done coincides with expiry: success wins
        req_b = 4'b1000;
        tick();
        chk("t6_gnt", 32'(gnt_b), 32'h8);
        tick();
        chk("t6_start", 32'(start_b), 1);
        repeat (16) tick();
        done_b = 1'b1;
        tick();
        chk("t6_done", 32'(rd_b), 32'h8);
        chk("t6_err", 32'(re_b), 0);
        done_b = 1'b0; req_b = '0;
        tick();
        chk("t6_count", cnt_b, 1);

        // stale done during GRANT must not complete the op
        base_d = n_done;
        req = 4'b0001;
        tick();
        chk("t4_gnt", 32'(gnt), 32'h1);
        mul_done = 1'b1;
        tick();
        mul_done = 1'b0;
        chk("t4_start", 32'(mul_start), 1);
        repeat (6) tick();
        chk("t4_no_done", 32'(req_done), 0);
        chk("t4_still_busy", 32'(arb_busy), 1);
        chk("t4_n_done_early", 32'(n_done - base_d), 0);
        mul_done = 1'b1;
        tick();
        chk("t4_done", 32'(req_done), 32'h1);
        mul_done = 1'b0; req = '0;
        tick();
        chk("t4_n_done", 32'(n_done - base_d), 1);
        chk("t4_count", mul_count, 9);

        // reset during WAIT, then core still busy
        req = 4'b0001;
        tick(); tick(); tick();
        chk("t5_in_wait", 32'(arb_busy), 1);
        #2 rst = 1'b0;
        #1;
        chk("t5_rst_gnt", 32'(gnt), 0);
        chk("t5_rst_sel", 32'(sel), 0);
        chk("t5_rst_start", 32'(mul_start), 0);
        chk("t5_rst_done", 32'(req_done), 0);
        chk("t5_rst_busy", 32'(arb_busy), 0);
        chk("t5_rst_count", mul_count, 0);
        mul_busy = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        saw = 1'b0;
        repeat (20) begin
            tick();
            if (gnt != 4'b0) saw = 1'b1;
        end
        chk("t5_blocked", 32'(saw), 0);
        mul_busy = 1'b0;
        tick();
        chk("t5_gnt", 32'(gnt), 32'h1);
        chk("t5_sel", 32'(sel), 0);
        tick(); tick();
        mul_done = 1'b1;
        tick();
        chk("t5_done", 32'(req_done), 32'h1);
        mul_done = 1'b0; req = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
